rsa_modexp_ctrl: RTL and testbench
==================================

Name: rsa_modexp_ctrl

Overview:
Sequencer for the RSA modular-exponentiation datapath. It accepts an exponent and drives the shared modular-multiplier unit through left-to-right binary square-and-multiply, one operation at a time, using a start/done handshake. It then signals completion on a valid/ready result channel that feeds the rsa output path. It holds no operand data; it issues only control to the datapath (load R=1, R=R*R, R=R*M).

Parameters:
EXP_W, 16, exponent width in bits (2..64)
CNT_W, 8, width of op counter; must satisfy 2^CNT_W > 2*EXP_W

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
cmd_valid_i  input  1  exponent command valid
cmd_ready_o  output  1  controller can accept a command (high only in IDLE)
exp_i  input  EXP_W  exponent, sampled on cmd_valid_i&&cmd_ready_o
init_o  output  1  one-cycle pulse: datapath loads R=1
mul_start_o  output  1  one-cycle pulse: datapath starts one modmul
mul_sel_o  output  1  operand select, 0=square (R*R), 1=multiply (R*M); held stable from start until done
mul_done_i  input  1  one-cycle pulse from datapath: current modmul finished, R updated
res_valid_o  output  1  exponentiation complete, R holds result
res_ready_i  input  1  downstream accepts result
busy_o  output  1  high in every state except IDLE
op_count_o  output  CNT_W  number of mul_start_o pulses issued for the current/last command

Behaviour:
- Reset (rst=1 at posedge): state=IDLE. cmd_ready_o=1, init_o=0, mul_start_o=0, mul_sel_o=0, res_valid_o=0, busy_o=0, op_count_o=0. Reset mid-operation aborts immediately. A later mul_done_i from the aborted op is ignored (IDLE ignores mul_done_i).
- States: IDLE, INIT, SCAN, ISSUE, WAIT, DONE.
- IDLE: cmd_ready_o=1. On handshake, latch exp_i into exp_r, clear op_count_o, set bit index idx=EXP_W-1, go to INIT.
- INIT (1 cycle): init_o=1. Go to SCAN.
- SCAN: skips leading zeros at one bit per cycle.
  - If exp_r[idx]=1: go to ISSUE with pending op=square.
  - Else if idx=0 (exp_r==0): go to DONE; result is 1 and 0 ops are issued.
  - Else: idx-=1.
  - Latency from accept to first mul_start_o = 2 + (number of leading zeros) cycles.
- ISSUE (1 cycle): mul_start_o=1; mul_sel_o=pending op; op_count_o+=1. Go to WAIT.
- WAIT: hold mul_sel_o. On mul_done_i:
  - If the op was a square and exp_r[idx]=1: pending=multiply, go to ISSUE.
  - Else if idx=0: go to DONE.
  - Else: idx-=1, pending=square, go to ISSUE.
  - mul_done_i in the same cycle as mul_start_o is not possible (minimum datapath latency is 1) and is ignored in ISSUE.
- Op sequence: for each bit from the MSB set bit down to bit 0, issue S, then M if the bit is 1. Total ops = (MSB index+1) + popcount(exp).
- DONE: res_valid_o=1, held until res_ready_i. On handshake go to IDLE; cmd_ready_o rises the next cycle. A command presented during DONE is not accepted (no back-to-back overlap). op_count_o keeps its final value until the next accept.
- Counter does not wrap for legal parameters; width rule enforced by the CNT_W constraint.
- mul_done_i outside WAIT: ignored, no state change.

Test Plan:
- exp_i=16'h0000 -> init_o pulse, 16 SCAN cycles, no mul_start_o, res_valid_o with op_count_o=0.
- exp_i=16'h0005, datapath done 3 cycles after each start -> mul_sel_o sequence 0,1,0,0,1; op_count_o=5; first mul_start_o 15 cycles after accept.
- exp_i=16'h8000 -> sequence 0,1 then fifteen 0s; op_count_o=17; first start 2 cycles after accept.
- exp_i=16'hFFFF with res_ready_i=0 for 10 cycles after res_valid_o -> op_count_o=32; res_valid_o held 10 cycles, cmd_ready_o=0 throughout, IDLE after ready.
- Reset asserted in WAIT during exp=16'h00FF, then stray mul_done_i -> all outputs return to reset values; stray done ignored; new command exp=16'h0001 yields ops 0,1, count 2.
- Spurious mul_done_i during SCAN and ISSUE -> no state or counter change; final count still matches the formula.

Source files
------------

// File: rtl/rsa_modexp_ctrl.sv
// Control sequencer for RSA modular exponentiation: walks the exponent MSB-first
// and drives the shared modular multiplier with square / multiply operations.
module rsa_modexp_ctrl #(
    parameter int EXP_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [EXP_W-1:0] exp_i,
    output logic             init_o,
    output logic             mul_start_o,
    output logic             mul_sel_o,
    input  logic             mul_done_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] op_count_o
);

    localparam int IDX_W = $clog2(EXP_W);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SCAN,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t           state;
    logic [EXP_W-1:0] exp_r;
    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            exp_r       <= '0;
            idx         <= '0;
            cmd_ready_o <= 1'b1;
            init_o      <= 1'b0;
            mul_start_o <= 1'b0;
            mul_sel_o   <= 1'b0;
            res_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            op_count_o  <= '0;
        end else begin
            // NOTE: pulse outputs default low here so every state only has to raise them.
            init_o      <= 1'b0;
            mul_start_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        exp_r       <= exp_i;
                        idx         <= IDX_W'(EXP_W - 1);
                        op_count_o  <= '0;
                        init_o      <= 1'b1;
                        cmd_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        state       <= INIT;
                    end
                end

                INIT: state <= SCAN;

                // Leading zeros are skipped one bit per cycle; the first set bit starts with a square.
                SCAN: begin
                    if (exp_r[idx]) begin
                        mul_start_o <= 1'b1;
                        mul_sel_o   <= 1'b0;
                        op_count_o  <= op_count_o + 1'b1;
                        state       <= ISSUE;
                    end else if (idx == '0) begin
                        res_valid_o <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end

                ISSUE: state <= WAIT;

                // mul_sel_o still names the op in flight, so it tells us whether this bit's
                // multiply is still owed.
                WAIT: begin
                    if (mul_done_i) begin
                        if (!mul_sel_o && exp_r[idx]) begin
                            mul_start_o <= 1'b1;
                            mul_sel_o   <= 1'b1;
                            op_count_o  <= op_count_o + 1'b1;
                            state       <= ISSUE;
                        end else if (idx == '0) begin
                            res_valid_o <= 1'b1;
                            state       <= DONE;
                        end else begin
                            idx         <= idx - 1'b1;
                            mul_start_o <= 1'b1;
                            mul_sel_o   <= 1'b0;
                            op_count_o  <= op_count_o + 1'b1;
                            state       <= ISSUE;
                        end
                    end
                end

                DONE: begin
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    cmd_ready_o <= 1'b1;
                    res_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Directed bench for rsa_modexp_ctrl: a small datapath stand-in answers each
// mul_start_o with mul_done_i three cycles later, and the op sequence is recorded.
module tb_rsa_modexp_ctrl;

    localparam int EXP_W  = 16;
    localparam int CNT_W  = 8;
    localparam int BUDGET = 2000;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [EXP_W-1:0] exp_i;
    logic             init_o;
    logic             mul_start_o;
    logic             mul_sel_o;
    logic             mul_done_i;
    logic             res_valid_o;
    logic             res_ready_i;
    logic             busy_o;
    logic [CNT_W-1:0] op_count_o;

    int n_tests = 0;
    int n_fail  = 0;

    rsa_modexp_ctrl #(.EXP_W(EXP_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .exp_i      (exp_i),
        .init_o     (init_o),
        .mul_start_o(mul_start_o),
        .mul_sel_o  (mul_sel_o),
        .mul_done_i (mul_done_i),
        .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i),
        .busy_o     (busy_o),
        .op_count_o (op_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready_o, 1);
        check({tag, "_init"},      init_o,      0);
        check({tag, "_start"},     mul_start_o, 0);
        check({tag, "_sel"},       mul_sel_o,   0);
        check({tag, "_res_valid"}, res_valid_o, 0);
        check({tag, "_busy"},      busy_o,      0);
        check({tag, "_count"},     op_count_o,  0);
    endtask

    // Runs one command end to end. exp_seq bit i is the mul_sel_o of op i.
    // exp_first / exp_res_k are cycles after the accept edge; -1 skips the check.
    task automatic run_cmd(input string tag, input logic [15:0] e,
                           input int exp_ops, input logic [63:0] exp_seq,
                           input int exp_first, input int exp_res_k,
                           input int ready_wait, input bit spur);
        int          k;
        int          done_at;
        int          first;
        int          nops;
        bit          fin;
        logic        cur;
        logic [63:0] seq;

        @(negedge clk);
        check({tag, "_ready_before"}, cmd_ready_o, 1);
        cmd_valid_i = 1'b1;
        exp_i       = e;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        check({tag, "_init_pulse"}, init_o, 1);
        check({tag, "_busy"}, busy_o, 1);
        check({tag, "_ready_low"}, cmd_ready_o, 0);

        k = 0; done_at = -1; first = -1; nops = 0; fin = 1'b0; cur = 1'b0; seq = '0;
        while (!fin && k < BUDGET) begin
            if (k == 1) check({tag, "_init_one_cycle"}, init_o, 0);
            if (mul_start_o) begin
                if (first < 0) first = k;
                if (nops < 64) seq[nops] = mul_sel_o;
                cur     = mul_sel_o;
                nops++;
                done_at = k + 2;
                if (spur) mul_done_i = 1'b1;  // lands while the DUT sits in ISSUE
            end else if (spur && k == 1) begin
                mul_done_i = 1'b1;            // lands while the DUT sits in SCAN
            end
            if (k == done_at) begin
                check({tag, "_sel_held"}, mul_sel_o, cur);
                mul_done_i = 1'b1;
            end
            if (res_valid_o) begin
                fin = 1'b1;
            end else begin
                @(negedge clk);
                mul_done_i = 1'b0;
                k++;
            end
        end
        check({tag, "_no_timeout"}, fin, 1);
        check({tag, "_count"}, op_count_o, exp_ops);
        check({tag, "_ops_seen"}, nops, exp_ops);
        check({tag, "_seq"}, seq, exp_seq);
        if (exp_first >= 0) check({tag, "_first_start"}, first, exp_first);
        if (exp_res_k >= 0) check({tag, "_done_cycle"}, k, exp_res_k);

        // Hold off the result; a competing command must not be taken meanwhile.
        for (int i = 0; i < ready_wait; i++) begin
            cmd_valid_i = 1'b1;
            exp_i       = 16'h0003;
            @(negedge clk);
            check({tag, "_res_held"}, res_valid_o, 1);
            check({tag, "_ready_held_low"}, cmd_ready_o, 0);
        end
        cmd_valid_i = 1'b0;
        res_ready_i = 1'b1;
        @(negedge clk);
        res_ready_i = 1'b0;
        check({tag, "_res_dropped"}, res_valid_o, 0);
        check({tag, "_idle_ready"}, cmd_ready_o, 1);
        check({tag, "_idle_busy"}, busy_o, 0);
        check({tag, "_count_kept"}, op_count_o, exp_ops);
    endtask

    initial begin
        rst         = 1'b1;
        cmd_valid_i = 1'b0;
        exp_i       = '0;
        mul_done_i  = 1'b0;
        res_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // exponent 0: no ops, DONE after INIT + 16 SCAN cycles
        run_cmd("exp0000", 16'h0000, 0, 64'h0, -1, 17, 0, 1'b0);
        // 101b: S M S S M, 13 leading zeros
        run_cmd("exp0005", 16'h0005, 5, 64'h12, 15, -1, 0, 1'b0);
        // MSB only: S M then fifteen S
        run_cmd("exp8000", 16'h8000, 17, 64'h2, 2, -1, 0, 1'b0);
        // all ones with the result stalled for 10 cycles
        run_cmd("expFFFF", 16'hFFFF, 32, 64'hAAAA_AAAA, 2, -1, 10, 1'b0);

        // Abort while waiting on the multiplier, then deliver a stray done.
        begin
            int  k;
            bit  seen;
            @(negedge clk);
            cmd_valid_i = 1'b1;
            exp_i       = 16'h00FF;
            @(negedge clk);
            cmd_valid_i = 1'b0;
            k = 0; seen = 1'b0;
            while (!seen && k < BUDGET) begin
                if (mul_start_o) seen = 1'b1;
                @(negedge clk);
                k++;
            end
            check("abort_start_seen", seen, 1);
            check("abort_busy_in_wait", busy_o, 1);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_reset_outputs("abort");
            mul_done_i = 1'b1;
            @(negedge clk);
            mul_done_i = 1'b0;
            @(negedge clk);
            check_reset_outputs("stray_done");
        end
        run_cmd("exp0001", 16'h0001, 2, 64'h2, 17, -1, 0, 1'b0);

        // Spurious done pulses in SCAN and ISSUE must not disturb anything.
        run_cmd("spur0005", 16'h0005, 5, 64'h12, 15, -1, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
